// File: rtl/logic_pll_lock_emulator_pkg.sv
// Shared types and elaboration-time helpers for the PLL lock emulator.
// All time-to-cycle conversions round up and never return fewer than 1 cycle.
package logic_pll_lock_emulator_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } pll_state_t;

  // ceil(ns * hz / 1e9) in 64-bit arithmetic, clamped to at least one cycle
  function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                               input longint unsigned hz);
    longint unsigned cycles;
    cycles = (ns * hz + 64'd999_999_999) / 64'd1_000_000_000;
    if (cycles < 64'd1) begin
      cycles = 64'd1;
    end
    return cycles[31:0];
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/logic_pll_lock_emulator_timer.sv
// Saturating up-counter shared by the HOLD (reset width) and LOCKING (lock delay) phases.
// Clear wins over enable; the count never passes the supplied limit.
module logic_pll_lock_emulator_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg < limit)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/logic_pll_lock_emulator.sv
// Emulates PLL lock behaviour: reset-width checking, lock delay, forced unlock and glitches.
// Every output is a flop; the FSM computes next values combinationally from registered state.
module logic_pll_lock_emulator
  import logic_pll_lock_emulator_pkg::*;
#(
  parameter longint unsigned CLOCK_FREQUENCY_HZ = 100_000_000,
  parameter longint unsigned MIN_RESET_NS       = 20,
  parameter longint unsigned LOCK_TIME_NS       = 100_000
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic       pll_reset,
  input  logic       unlock_request,
  input  logic       glitch_request,
  output logic       pll_locked,
  output logic [7:0] lock_count,
  output logic       reset_too_short
);

  localparam int unsigned RESET_CYCLES = ns_to_cycles(MIN_RESET_NS, CLOCK_FREQUENCY_HZ);
  localparam int unsigned LOCK_CYCLES  = ns_to_cycles(LOCK_TIME_NS, CLOCK_FREQUENCY_HZ);
  localparam int unsigned TIMER_W      = $clog2(max_u(RESET_CYCLES, LOCK_CYCLES) + 1);

  localparam logic [TIMER_W-1:0] RESET_LIMIT  = TIMER_W'(RESET_CYCLES);
  localparam logic [TIMER_W-1:0] RESET_THRESH = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LIMIT   = TIMER_W'(LOCK_CYCLES);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);

  pll_state_t       state_reg, state_next;
  logic             locked_reg, locked_next;
  logic [7:0]       count_reg, count_next;
  logic             short_reg, short_next;

  logic             timer_clear;
  logic             timer_enable;
  logic [TIMER_W-1:0] timer_limit;
  logic [TIMER_W-1:0] timer_count;

  logic_pll_lock_emulator_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk    (aclk),
    .srst   (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit),
    .count  (timer_count)
  );

  always_comb begin
    state_next   = state_reg;
    locked_next  = 1'b0;
    count_next   = count_reg;
    short_next   = short_reg;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    timer_limit  = LOCK_LIMIT;

    if (pll_reset) begin
      state_next = HOLD;
      // The entry cycle is not counted, so the release check uses RESET_CYCLES-1.
      if (state_reg != HOLD) begin
        timer_clear = 1'b1;
      end else begin
        timer_enable = 1'b1;
        timer_limit  = RESET_LIMIT;
      end
    end else begin
      case (state_reg)
        HOLD: begin
          timer_clear = 1'b1;
          if (timer_count >= RESET_THRESH) begin
            state_next = LOCKING;
          end else begin
            state_next = LOST;
            short_next = 1'b1;
          end
        end
        LOCKING: begin
          if (timer_count == LOCK_LAST) begin
            state_next  = LOCKED;
            locked_next = 1'b1;
            if (count_reg != 8'hFF) begin
              count_next = count_reg + 8'd1;
            end
          end else begin
            timer_enable = 1'b1;
          end
        end
        LOCKED: begin
          if (unlock_request) begin
            state_next = LOST;
          end else begin
            locked_next = !glitch_request;
          end
        end
        default: begin
          state_next = LOST;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_reg  <= LOCKING;
      locked_reg <= 1'b0;
      count_reg  <= 8'd0;
      short_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= locked_next;
      count_reg  <= count_next;
      short_reg  <= short_next;
    end
  end

  assign pll_locked      = locked_reg;
  assign lock_count      = count_reg;
  assign reset_too_short = short_reg;

endmodule

// File: tb/tb_logic_pll_lock_emulator.sv
// Self-checking bench: deadline-based reference model compared every cycle, plus literal checkpoints.
// Runs at 100 MHz with a 5-cycle minimum reset and a 100-cycle lock time.
module tb_logic_pll_lock_emulator;

  localparam int RC = 5;    // ceil(50 ns * 100 MHz)
  localparam int LC = 100;  // ceil(1000 ns * 100 MHz)

  logic       aclk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_reset = 1'b0;
  logic       unlock_request = 1'b0;
  logic       glitch_request = 1'b0;
  logic       pll_locked;
  logic [7:0] lock_count;
  logic       reset_too_short;

  int checks = 0;
  int errors = 0;

  logic_pll_lock_emulator #(
    .CLOCK_FREQUENCY_HZ (100_000_000),
    .MIN_RESET_NS       (50),
    .LOCK_TIME_NS       (1000)
  ) dut (
    .aclk            (aclk),
    .reset           (reset),
    .pll_reset       (pll_reset),
    .unlock_request  (unlock_request),
    .glitch_request  (glitch_request),
    .pll_locked      (pll_locked),
    .lock_count      (lock_count),
    .reset_too_short (reset_too_short)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lock is a deadline (edge index) set by a valid release or by reset.
  int cyc = 0;
  int lock_due = -1;
  bit model_valid = 0;
  bit is_locked = 0;
  bit holding = 0;
  int hold_len = 0;
  bit m_locked = 0;
  int m_count = 0;
  bit m_flag = 0;

  always @(posedge aclk) begin
    cyc++;
    if (reset) begin
      model_valid = 1;
      holding = 0; is_locked = 0; lock_due = cyc + LC;
      m_locked = 0; m_count = 0; m_flag = 0;
    end else if (pll_reset) begin
      if (!holding) hold_len = 0;
      holding = 1; hold_len++;
      lock_due = -1; is_locked = 0; m_locked = 0;
    end else if (holding) begin
      holding = 0;
      if (hold_len >= RC) lock_due = cyc + LC;
      else m_flag = 1;
      m_locked = 0;
    end else if (is_locked) begin
      if (unlock_request) begin
        is_locked = 0; m_locked = 0;
      end else begin
        m_locked = !glitch_request;
      end
    end else if (lock_due == cyc) begin
      is_locked = 1; m_locked = 1;
      if (m_count < 255) m_count++;
    end else begin
      m_locked = 0;
    end
    #1;
    if (model_valid) begin
      check("model pll_locked", int'(pll_locked), int'(m_locked));
      check("model lock_count", int'(lock_count), m_count);
      check("model reset_too_short", int'(reset_too_short), int'(m_flag));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pll_pulse(input int n);
    pll_reset = 1'b1;
    cycles(n);
    pll_reset = 1'b0;
  endtask

  initial begin
    cycles(3);
    check("reset pll_locked", int'(pll_locked), 0);
    check("reset lock_count", int'(lock_count), 0);
    check("reset flag", int'(reset_too_short), 0);

    // Power-up lock without pll_reset
    reset = 1'b0;
    cycles(99);
    check("powerup not yet locked", int'(pll_locked), 0);
    cycles(1);
    check("powerup locked", int'(pll_locked), 1);
    check("powerup lock_count", int'(lock_count), 1);
    $display("power-up: locked=%0d count=%0d", pll_locked, lock_count);

    // Valid 5-cycle pll_reset
    pll_reset = 1'b1;
    cycles(1);
    check("valid reset drops lock", int'(pll_locked), 0);
    cycles(4);
    pll_reset = 1'b0;
    cycles(100);
    check("valid relock early", int'(pll_locked), 0);
    cycles(1);
    check("valid relock", int'(pll_locked), 1);
    check("valid lock_count", int'(lock_count), 2);
    $display("valid reset: locked=%0d count=%0d", pll_locked, lock_count);

    // Two-cycle glitch
    cycles(5);
    glitch_request = 1'b1;
    cycles(1);
    check("glitch cycle 1", int'(pll_locked), 0);
    cycles(1);
    check("glitch cycle 2", int'(pll_locked), 0);
    glitch_request = 1'b0;
    cycles(1);
    check("glitch recovered", int'(pll_locked), 1);
    check("glitch lock_count", int'(lock_count), 2);
    $display("glitch: locked=%0d count=%0d", pll_locked, lock_count);

    // Simultaneous pll_reset, unlock and glitch
    pll_reset = 1'b1; unlock_request = 1'b1; glitch_request = 1'b1;
    cycles(1);
    unlock_request = 1'b0; glitch_request = 1'b0;
    check("simultaneous lock low", int'(pll_locked), 0);
    check("simultaneous flag", int'(reset_too_short), 0);
    cycles(4);
    pll_reset = 1'b0;
    cycles(101);
    check("simultaneous relock", int'(pll_locked), 1);
    check("simultaneous count", int'(lock_count), 3);
    $display("simultaneous: locked=%0d count=%0d", pll_locked, lock_count);

    // Forced unlock, no self-relock
    unlock_request = 1'b1;
    cycles(1);
    unlock_request = 1'b0;
    check("unlock low", int'(pll_locked), 0);
    cycles(200);
    check("unlock stays low", int'(pll_locked), 0);
    $display("unlock: locked=%0d", pll_locked);

    // Short reset then recovery
    pll_pulse(3);
    cycles(1000);
    check("short stays unlocked", int'(pll_locked), 0);
    check("short flag", int'(reset_too_short), 1);
    pll_pulse(6);
    cycles(101);
    check("short recovery lock", int'(pll_locked), 1);
    check("short flag sticky", int'(reset_too_short), 1);
    check("short recovery count", int'(lock_count), 4);
    $display("short reset: flag=%0d locked=%0d", reset_too_short, pll_locked);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      pll_pulse(5);
      cycles(101);
    end
    check("saturated count", int'(lock_count), 255);
    check("saturated locked", int'(pll_locked), 1);
    $display("saturation: count=%0d", lock_count);

    // Reset mid-LOCKING at timer 50
    pll_pulse(5);
    cycles(51);
    reset = 1'b1;
    cycles(2);
    check("midreset locked", int'(pll_locked), 0);
    check("midreset count", int'(lock_count), 0);
    check("midreset flag", int'(reset_too_short), 0);
    reset = 1'b0;
    cycles(99);
    check("midreset early", int'(pll_locked), 0);
    cycles(1);
    check("midreset relock", int'(pll_locked), 1);
    $display("mid reset: locked=%0d count=%0d", pll_locked, lock_count);

    // Randomized traffic, checked every cycle by the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cycles($urandom_range(1, 3));
        reset = 1'b0;
      end
      pll_pulse($urandom_range(1, 8));
      for (int c = 0; c < int'($urandom_range(0, 130)); c++) begin
        unlock_request = ($urandom_range(0, 99) < 2);
        glitch_request = ($urandom_range(0, 99) < 5);
        cycles(1);
      end
      unlock_request = 1'b0;
      glitch_request = 1'b0;
      $display("random %0d: locked=%0d count=%0d flag=%0d", it, pll_locked, lock_count, reset_too_short);
    end
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
